mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one SRAM_wrapper macro between the IF fetch port and the MEM load/store port,
// so a single-memory build (unified I/D space) runs on the same 5-stage pipeline.
// Grants one access per cycle, returns read data one cycle after grant, and raises
// per-port stalls the Controller ORs into stall/MEM_stall. Fixed data priority, fetch anti-starvation.
// PARAMETERS
// ADDR_W         14  SRAM word-address width
// DATA_W         32  data width (4 byte lanes)
// MAX_DM_STREAK  4   consecutive DM grants allowed while IF waits (1..15)
// PORTS
// clk        in   1       clock, all state on rising edge
// rst        in   1       asynchronous, active-high reset
// if_req     in   1       fetch request, held with if_addr until if_gnt
// if_addr    in   ADDR_W  fetch word address
// if_flush   in   1       jb redirect: discard fetch response due this cycle
// if_gnt     out  1       fetch issued to SRAM this cycle (comb)
// if_rvalid  out  1       if_rdata valid (registered)
// if_rdata   out  DATA_W  fetched instruction
// if_stall   out  1       if_req & ~if_gnt
// dm_req     in   1       data request, held with addr/web/wdata until dm_gnt
// dm_web     in   4       active-low byte write enables; 4'hF = read
// dm_addr    in   ADDR_W  data word address
// dm_wdata   in   DATA_W  store data (lane-aligned)
// dm_gnt     out  1       data access issued this cycle (comb)
// dm_rvalid  out  1       dm_rdata valid, reads only (registered)
// dm_rdata   out  DATA_W  load data, raw word (LD_Filter downstream)
// dm_stall   out  1       dm_req & ~dm_gnt
// sram_cs    out  1       SRAM chip select
// sram_oe    out  1       SRAM output enable
// sram_web   out  4       SRAM byte write enables, active-low
// sram_a     out  ADDR_W  SRAM address
// sram_di    out  DATA_W  SRAM write data
// sram_do    in   DATA_W  SRAM read data
// BEHAVIOUR
// - Grant (comb): only dm_req -> DM; only if_req -> IF; both -> DM unless streak==MAX_DM_STREAK, then IF.
// - streak: 4-bit; +1 on DM grant while if_req high; cleared on IF grant or if_req low; saturates at MAX.
// - Grant cycle: sram_cs=1, sram_a/sram_web/sram_di from winner; IF grant drives sram_web=4'hF, sram_di=0.
//   No grant: sram_cs=0, sram_web=4'hF, sram_a/sram_di=0.
// - Response FSM (owner reg): NONE, IF_RD, DM_RD. Next = IF_RD on IF grant, DM_RD on DM read grant,
//   else NONE (DM writes never produce a response). Back-to-back grants: one per cycle, no bubble.
// - sram_oe = 1 in grant cycle of any read and in the following response cycle; 0 otherwise.
// - Response cycle (owner != NONE): if_rdata/dm_rdata = sram_do; if_rvalid=(owner==IF_RD)&~if_flush;
//   dm_rvalid=(owner==DM_RD). rdata outputs hold last returned value otherwise.
// - Latency: read data 1 cycle after gnt; write completes in gnt cycle.
// - if_flush in a grant cycle does not cancel that grant; it only masks rvalid in a response cycle.
// - Reset (async, any state incl. mid-response): owner=NONE, streak=0, if_rvalid=dm_rvalid=0,
//   if_rdata=dm_rdata=0, sram_oe=0, sram_cs=0, sram_web=4'hF; in-flight response dropped.
// - Request changing before gnt is a protocol error; arbiter samples only in grant cycle, no checks.
// TESTING
// 1 IF-only: if_req=1 addr 0x0010 x3 cycles -> if_gnt each cycle, if_rvalid 1 cycle later each, data=mem[0x10..]
// 2 Contention: both req, MAX=4 -> DM,DM,DM,DM,IF grant pattern; if_stall=1 for 4 cycles, then streak=0
// 3 Store then load same addr 0x0100, web=4'b1100 wdata=0xAABBCCDD over 0x11223344 -> dm_rvalid, rdata=0x1122CCDD
// 4 Flush: IF grant cycle N, if_flush=1 at N+1 -> if_rvalid=0 at N+1; DM grant at N+1 unaffected
// 5 DM write only: dm_web=4'h0 -> dm_gnt=1, sram_oe=0, no dm_rvalid next cycle
// 6 rst pulse mid read response -> rvalid=0 immediately, sram_cs=0, streak=0; normal grant after release

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets the IF fetch port and the MEM load/store port share one single-ported
// SRAM macro. One access is granted per cycle. Read data comes back one cycle
// after the grant. Data accesses normally win. After MAX_DM_STREAK consecutive
// data grants while a fetch is waiting, the fetch is served once.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   if_req/if_addr           fetch request and word address
//   if_flush                 masks the fetch response returned this cycle
//   if_gnt/if_stall          fetch issued this cycle / fetch waiting
//   if_rvalid/if_rdata       fetch response
//   dm_req/dm_web/dm_addr/dm_wdata  data request (dm_web 4'hF = read)
//   dm_gnt/dm_stall          data access issued this cycle / data waiting
//   dm_rvalid/dm_rdata       load response (reads only)
//   sram_cs/oe/web/a/di/do   SRAM macro interface
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 14,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic [3:0]        dm_web,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic [3:0]        sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF_RD,
        OWN_DM_RD
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    owner_t            r_owner;
    owner_t            w_owner_nxt;
    logic [3:0]        r_streak;
    logic [3:0]        w_streak_nxt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              w_if_gnt;
    logic              w_dm_gnt;
    logic              w_rd_gnt;

    // Grants are gated by rst so the SRAM is idle while reset is asserted,
    // even though the requests themselves are combinational inputs.
    always_comb begin
        w_dm_gnt = 1'b0;
        w_if_gnt = 1'b0;
        if (!rst) begin
            w_dm_gnt = dm_req && !(if_req && (r_streak == STREAK_MAX));
            w_if_gnt = if_req && !w_dm_gnt;
        end
        w_rd_gnt = w_if_gnt || (w_dm_gnt && (dm_web == 4'hF));
    end

    // Next-state for the response owner and the DM streak counter
    always_comb begin
        w_owner_nxt  = OWN_NONE;
        w_streak_nxt = r_streak;
        if (w_if_gnt) begin
            w_owner_nxt = OWN_IF_RD;
        end else if (w_dm_gnt && (dm_web == 4'hF)) begin
            w_owner_nxt = OWN_DM_RD;
        end
        if (w_if_gnt || !if_req) begin
            w_streak_nxt = '0;
        end else if (w_dm_gnt && (r_streak != STREAK_MAX)) begin
            w_streak_nxt = r_streak + 4'd1;
        end
    end

    // SRAM drive: winner's request in a grant cycle, quiet otherwise
    always_comb begin
        sram_cs  = 1'b0;
        sram_web = 4'hF;
        sram_a   = '0;
        sram_di  = '0;
        if (w_dm_gnt) begin
            sram_cs  = 1'b1;
            sram_web = dm_web;
            sram_a   = dm_addr;
            sram_di  = dm_wdata;
        end else if (w_if_gnt) begin
            sram_cs = 1'b1;
            sram_a  = if_addr;
        end
        sram_oe = w_rd_gnt || (r_owner != OWN_NONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= OWN_NONE;
            r_streak   <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_streak <= w_streak_nxt;
            if (r_owner == OWN_IF_RD) begin
                r_if_rdata <= sram_do;
            end
            if (r_owner == OWN_DM_RD) begin
                r_dm_rdata <= sram_do;
            end
        end
    end

    // Response data passes straight through in the response cycle and is
    // then held, so each rdata output always shows its last returned word.
    assign if_rdata  = (r_owner == OWN_IF_RD) ? sram_do : r_if_rdata;
    assign dm_rdata  = (r_owner == OWN_DM_RD) ? sram_do : r_dm_rdata;
    assign if_rvalid = (r_owner == OWN_IF_RD) && !if_flush;
    assign dm_rvalid = (r_owner == OWN_DM_RD);

    assign if_gnt   = w_if_gnt;
    assign dm_gnt   = w_dm_gnt;
    assign if_stall = if_req && !w_if_gnt;
    assign dm_stall = dm_req && !w_dm_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM model
// (registered read data, byte-lane writes). The memory is preloaded with
// 32'hA500_0000 | index, so expected read data is known by construction.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    logic              dm_req;
    logic [3:0]        dm_web;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;
    logic              sram_cs;
    logic              sram_oe;
    logic [3:0]        sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_di;
    logic [DATA_W-1:0] sram_do;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_DM_STREAK(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_stall (if_stall),
        .dm_req   (dm_req),
        .dm_web   (dm_web),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .dm_stall (dm_stall),
        .sram_cs  (sram_cs),
        .sram_oe  (sram_oe),
        .sram_web (sram_web),
        .sram_a   (sram_a),
        .sram_di  (sram_di),
        .sram_do  (sram_do)
    );

    always #5 clk = ~clk;

    // SRAM model
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_do;
    assign sram_do = r_do;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA500_0000 | i;
        mem[14'h100] = 32'h1122_3344;
        r_do = '0;
    end

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_web == 4'hF) begin
                r_do <= mem[sram_a];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (!sram_web[b]) mem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Move to 1 time unit after the next rising edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req   = 1'b0;
        dm_req   = 1'b0;
        if_flush = 1'b0;
        dm_web   = 4'hF;
    endtask

    initial begin
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        if_flush = 1'b0;
        dm_req   = 1'b0;
        dm_web   = 4'hF;
        dm_addr  = '0;
        dm_wdata = '0;

        // Reset state
        #2;
        chk("rst_cs",      {31'd0, sram_cs},   32'd0);
        chk("rst_oe",      {31'd0, sram_oe},   32'd0);
        chk("rst_web",     {28'd0, sram_web},  32'hF);
        chk("rst_if_rv",   {31'd0, if_rvalid}, 32'd0);
        chk("rst_dm_rv",   {31'd0, dm_rvalid}, 32'd0);
        chk("rst_if_rd",   if_rdata,           32'd0);
        chk("rst_dm_rd",   dm_rdata,           32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: IF-only, three back-to-back fetches from 0x0010
        nxt();
        for (int k = 0; k < 4; k++) begin
            if_req  = (k < 3);
            if_addr = 14'h10 + 14'(k);
            #2;
            chk("t1_if_gnt", {31'd0, if_gnt}, (k < 3) ? 32'd1 : 32'd0);
            chk("t1_if_rv",  {31'd0, if_rvalid}, (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) chk("t1_if_rd", if_rdata, 32'hA500_0010 + 32'(k - 1));
            if (k < 3) chk("t1_sram_a", {18'd0, sram_a}, 32'h10 + 32'(k));
            nxt();
        end
        #2;
        chk("t1_rv_end", {31'd0, if_rvalid}, 32'd0);
        chk("t1_rd_hold", if_rdata, 32'hA500_0012);
        chk("t1_cs_idle", {31'd0, sram_cs}, 32'd0);
        chk("t1_oe_idle", {31'd0, sram_oe}, 32'd0);
        nxt();

        // 2: contention, MAX=4 -> DM x4 then IF, repeated twice
        if_req  = 1'b1;
        if_addr = 14'h30;
        dm_req  = 1'b1;
        dm_web  = 4'hF;
        dm_addr = 14'h20;
        for (int k = 0; k < 10; k++) begin
            #2;
            chk("t2_dm_gnt",  {31'd0, dm_gnt},   (k == 4 || k == 9) ? 32'd0 : 32'd1);
            chk("t2_if_gnt",  {31'd0, if_gnt},   (k == 4 || k == 9) ? 32'd1 : 32'd0);
            chk("t2_if_stall",{31'd0, if_stall}, (k == 4 || k == 9) ? 32'd0 : 32'd1);
            chk("t2_dm_stall",{31'd0, dm_stall}, (k == 4 || k == 9) ? 32'd1 : 32'd0);
            if (k > 0) begin
                chk("t2_if_rv", {31'd0, if_rvalid}, (k == 5) ? 32'd1 : 32'd0);
                chk("t2_dm_rv", {31'd0, dm_rvalid}, (k == 5) ? 32'd0 : 32'd1);
            end
            if (k == 5) chk("t2_if_rd", if_rdata, 32'hA500_0030);
            if (k == 6) chk("t2_dm_rd", dm_rdata, 32'hA500_0020);
            nxt();
        end
        idle();
        nxt();

        // 3 + 5: partial store then load at 0x0100
        dm_req   = 1'b1;
        dm_addr  = 14'h100;
        dm_web   = 4'b1100;
        dm_wdata = 32'hAABB_CCDD;
        #2;
        chk("t3_st_gnt", {31'd0, dm_gnt},    32'd1);
        chk("t3_st_web", {28'd0, sram_web},  32'hC);
        chk("t3_st_oe",  {31'd0, sram_oe},   32'd0);
        chk("t3_st_di",  sram_di,            32'hAABB_CCDD);
        nxt();
        dm_web = 4'hF;
        #2;
        chk("t3_no_rv",  {31'd0, dm_rvalid}, 32'd0);
        chk("t3_ld_gnt", {31'd0, dm_gnt},    32'd1);
        chk("t3_ld_oe",  {31'd0, sram_oe},   32'd1);
        nxt();
        idle();
        #2;
        chk("t3_ld_rv",  {31'd0, dm_rvalid}, 32'd1);
        chk("t3_ld_rd",  dm_rdata,           32'h1122_CCDD);
        nxt();

        // 5: full-word write, no response, then read back
        dm_req   = 1'b1;
        dm_addr  = 14'h200;
        dm_web   = 4'h0;
        dm_wdata = 32'hDEAD_BEEF;
        #2;
        chk("t5_gnt", {31'd0, dm_gnt},  32'd1);
        chk("t5_oe",  {31'd0, sram_oe}, 32'd0);
        nxt();
        idle();
        #2;
        chk("t5_no_rv", {31'd0, dm_rvalid}, 32'd0);
        chk("t5_oe2",   {31'd0, sram_oe},   32'd0);
        chk("t5_hold",  dm_rdata,           32'h1122_CCDD);
        dm_req = 1'b1;
        dm_web = 4'hF;
        nxt();
        idle();
        #2;
        chk("t5_rb", dm_rdata, 32'hDEAD_BEEF);
        nxt();

        // 4: flush masks the IF response; DM grant in that cycle unaffected
        if_req  = 1'b1;
        if_addr = 14'h40;
        #2;
        chk("t4_if_gnt", {31'd0, if_gnt}, 32'd1);
        nxt();
        if_req   = 1'b0;
        if_flush = 1'b1;
        dm_req   = 1'b1;
        dm_web   = 4'hF;
        dm_addr  = 14'h50;
        #2;
        chk("t4_if_rv",  {31'd0, if_rvalid}, 32'd0);
        chk("t4_dm_gnt", {31'd0, dm_gnt},    32'd1);
        chk("t4_oe",     {31'd0, sram_oe},   32'd1);
        nxt();
        idle();
        #2;
        chk("t4_dm_rv",  {31'd0, dm_rvalid}, 32'd1);
        chk("t4_dm_rd",  dm_rdata,           32'hA500_0050);
        chk("t4_if_rv2", {31'd0, if_rvalid}, 32'd0);
        nxt();

        // 6: reset in the middle of a DM read response
        if_req  = 1'b1;
        if_addr = 14'h70;
        dm_req  = 1'b1;
        dm_web  = 4'hF;
        dm_addr = 14'h60;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("t6_dm_gnt", {31'd0, dm_gnt}, 32'd1);
            nxt();
        end
        #2;
        chk("t6_if_gnt", {31'd0, if_gnt},    32'd1);
        chk("t6_pre_rv", {31'd0, dm_rvalid}, 32'd1);
        chk("t6_pre_rd", dm_rdata,           32'hA500_0060);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_rv",  {31'd0, dm_rvalid}, 32'd0);
        chk("t6_rst_rd",  dm_rdata,           32'd0);
        chk("t6_rst_cs",  {31'd0, sram_cs},   32'd0);
        chk("t6_rst_oe",  {31'd0, sram_oe},   32'd0);
        chk("t6_rst_web", {28'd0, sram_web},  32'hF);
        chk("t6_rst_ig",  {31'd0, if_gnt},    32'd0);
        #1;
        rst = 1'b0;
        #1;
        // streak cleared: DM wins again despite the waiting fetch
        chk("t6_rel_dm", {31'd0, dm_gnt},  32'd1);
        chk("t6_rel_if", {31'd0, if_gnt},  32'd0);
        chk("t6_rel_cs", {31'd0, sram_cs}, 32'd1);
        nxt();
        #2;
        chk("t6_post_rv", {31'd0, dm_rvalid}, 32'd1);
        chk("t6_post_rd", dm_rdata,           32'hA500_0060);
        chk("t6_post_dm", {31'd0, dm_gnt},    32'd1);
        idle();
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
